// File: rtl/mining_job_dispatcher_if.sv
// rtl/mining_job_dispatcher_if.sv - job word stream and result port between host bridge and dispatcher
//
// Signals:
//   in_valid/in_ready/in_data[31:0]/in_last   job word stream, host -> dispatcher
//   res_valid/res_ready                        result handshake, dispatcher -> host
//   res_success/res_timeout/res_aborted        result status flags
//   res_nonce[31:0]/res_hash[255:0]            result payload
// Modports: master = host side, slave = dispatcher side.
interface mining_job_dispatcher_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         res_valid;
    logic         res_ready;
    logic         res_success;
    logic         res_timeout;
    logic         res_aborted;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_success, res_timeout, res_aborted, res_nonce, res_hash
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_success, res_timeout, res_aborted, res_nonce, res_hash
    );
endinterface

// File: rtl/mining_job_dispatcher.sv
// rtl/mining_job_dispatcher.sv - loads a 20-word header job, runs the supervisor, returns its result
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   host (slave modport)              job word stream in, result handshake out
//   abort                             host abort of the current job (level)
//   sup_reset, sup_start              supervisor control (never both high)
//   version, timestamp, bits, target_bits, hashPrevBlock, hashMerkleRoot   header to supervisor
//   process_complete, success, hash_out, nonce_out                        supervisor result
//   busy                              state != IDLE
//   load_error                        sticky malformed-job flag, cleared by next good load
//   jobs_done                         count of delivered results (wraps)
// Parameters:
//   RESET_CYCLES    cycles the supervisor is held in reset before start (>=2)
//   TIMEOUT_CYCLES  run-cycle limit before forced abort; 0 disables
module mining_job_dispatcher #(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mining_job_dispatcher_if.slave  host,
    input  logic                    abort,
    output logic                    sup_reset,
    output logic                    sup_start,
    output logic [31:0]             version,
    output logic [31:0]             timestamp,
    output logic [31:0]             bits,
    output logic [31:0]             target_bits,
    output logic [255:0]            hashPrevBlock,
    output logic [255:0]            hashMerkleRoot,
    input  logic                    process_complete,
    input  logic                    success,
    input  logic [255:0]            hash_out,
    input  logic [31:0]             nonce_out,
    output logic                    busy,
    output logic                    load_error,
    output logic [15:0]             jobs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_CLEAR,
        S_RUN,
        S_REPORT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    word_idx;
    logic [31:0]   cnt;            // cycles spent in CLEAR or RUN
    logic          in_ready_q;
    logic          res_valid_q;
    logic          res_success_q;
    logic          res_timeout_q;
    logic          res_aborted_q;
    logic [31:0]   res_nonce_q;
    logic [255:0]  res_hash_q;

    logic          accept;
    logic          loading;
    logic          last_word;
    logic          clear_done;
    logic          timeout_hit;
    logic [7:0]    hash_slot;

    assign host.in_ready    = in_ready_q;
    assign host.res_valid   = res_valid_q;
    assign host.res_success = res_success_q;
    assign host.res_timeout = res_timeout_q;
    assign host.res_aborted = res_aborted_q;
    assign host.res_nonce   = res_nonce_q;
    assign host.res_hash    = res_hash_q;

    assign accept      = host.in_valid & in_ready_q;
    assign loading     = (state == S_IDLE) || (state == S_LOAD);
    assign last_word   = (word_idx == 5'd19);
    assign clear_done  = (cnt == 32'(RESET_CYCLES - 1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
    // Words 1..8 and 9..16 both map to slot (k-1) mod 8 of their 256-bit field.
    assign hash_slot   = {word_idx[2:0] - 3'd1, 5'd0};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept) begin
                    if (host.in_last)
                        state_nxt = last_word ? S_CLEAR : S_IDLE;
                    else
                        state_nxt = last_word ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (abort || (accept && host.in_last))
                    state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (clear_done)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (process_complete || abort || timeout_hit)
                    state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (res_valid_q && host.res_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            word_idx       <= 5'd0;
            cnt            <= 32'd0;
            sup_reset      <= 1'b1;
            sup_start      <= 1'b0;
            in_ready_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            res_success_q  <= 1'b0;
            res_timeout_q  <= 1'b0;
            res_aborted_q  <= 1'b0;
            res_nonce_q    <= 32'd0;
            res_hash_q     <= 256'd0;
            version        <= 32'd0;
            timestamp      <= 32'd0;
            bits           <= 32'd0;
            target_bits    <= 32'd0;
            hashPrevBlock  <= 256'd0;
            hashMerkleRoot <= 256'd0;
            busy           <= 1'b0;
            load_error     <= 1'b0;
            jobs_done      <= 16'd0;
        end else begin
            state <= state_nxt;

            // Outputs are registered from the next state so they track the state exactly.
            sup_reset   <= (state_nxt != S_RUN);
            sup_start   <= (state_nxt == S_RUN);
            in_ready_q  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
            res_valid_q <= (state_nxt == S_REPORT);
            busy        <= (state_nxt != S_IDLE);

            if ((state_nxt == state) && ((state == S_CLEAR) || (state == S_RUN)))
                cnt <= cnt + 32'd1;
            else
                cnt <= 32'd0;

            if (state_nxt == S_LOAD)
                word_idx <= accept ? word_idx + 5'd1 : word_idx;
            else
                word_idx <= 5'd0;

            if (loading && accept && !abort) begin
                if (word_idx == 5'd0)
                    version <= host.in_data;
                else if (word_idx <= 5'd8)
                    hashPrevBlock[hash_slot +: 32] <= host.in_data;
                else if (word_idx <= 5'd16)
                    hashMerkleRoot[hash_slot +: 32] <= host.in_data;
                else if (word_idx == 5'd17)
                    timestamp <= host.in_data;
                else if (word_idx == 5'd18)
                    bits <= host.in_data;
                else
                    target_bits <= host.in_data;

                if (host.in_last)
                    load_error <= !last_word;
                else if (last_word)
                    load_error <= 1'b1;
            end

            if (state == S_RUN) begin
                if (process_complete) begin
                    res_success_q <= success;
                    res_nonce_q   <= nonce_out;
                    res_hash_q    <= hash_out;
                    res_timeout_q <= 1'b0;
                    res_aborted_q <= 1'b0;
                end else if (abort) begin
                    res_success_q <= 1'b0;
                    res_nonce_q   <= 32'd0;
                    res_hash_q    <= 256'd0;
                    res_timeout_q <= 1'b0;
                    res_aborted_q <= 1'b1;
                end else if (timeout_hit) begin
                    res_success_q <= 1'b0;
                    res_nonce_q   <= 32'd0;
                    res_hash_q    <= 256'd0;
                    res_timeout_q <= 1'b1;
                    res_aborted_q <= 1'b0;
                end
            end

            if ((state == S_REPORT) && res_valid_q && host.res_ready)
                jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_mining_job_dispatcher.sv
// tb/tb_mining_job_dispatcher.sv - self-checking bench for mining_job_dispatcher
module tb_mining_job_dispatcher;

    localparam int RC = 2;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         abort = 1'b0;
    logic         sup_reset, sup_start;
    logic [31:0]  version, timestamp, bits, target_bits;
    logic [255:0] hashPrevBlock, hashMerkleRoot;
    logic         process_complete = 1'b0;
    logic         success = 1'b0;
    logic [255:0] hash_out = '0;
    logic [31:0]  nonce_out = '0;
    logic         busy, load_error;
    logic [15:0]  jobs_done;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;
    logic [31:0] jw [24];

    always #5 clk = ~clk;

    mining_job_dispatcher_if bus ();

    mining_job_dispatcher #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .host             (bus),
        .abort            (abort),
        .sup_reset        (sup_reset),
        .sup_start        (sup_start),
        .version          (version),
        .timestamp        (timestamp),
        .bits             (bits),
        .target_bits      (target_bits),
        .hashPrevBlock    (hashPrevBlock),
        .hashMerkleRoot   (hashMerkleRoot),
        .process_complete (process_complete),
        .success          (success),
        .hash_out         (hash_out),
        .nonce_out        (nonce_out),
        .busy             (busy),
        .load_error       (load_error),
        .jobs_done        (jobs_done)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void fill_job();
        for (int i = 0; i < 24; i++) jw[i] = $urandom;
    endfunction

    // Send words 0..n-1, in_last on word last_at; returns at the negedge after the final accept.
    task automatic send(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            int b;
            bus.in_valid = 1'b1;
            bus.in_data  = jw[i];
            bus.in_last  = (i == last_at);
            b = 0;
            while (!bus.in_ready && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (b >= 50) chk("in_ready_wait", bus.in_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 1;
        while (!sup_start && k < 20) begin
            chk("clear_sup_reset", sup_reset, 1'b1);
            chk("clear_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            k++;
        end
        chk("start_latency", k, RC + 1);
        chk("run_sup_reset", sup_reset, 1'b0);
    endtask

    task automatic check_header();
        chk("hdr_version", version, jw[0]);
        chk("hdr_prev", hashPrevBlock, {jw[8], jw[7], jw[6], jw[5], jw[4], jw[3], jw[2], jw[1]});
        chk("hdr_merkle", hashMerkleRoot, {jw[16], jw[15], jw[14], jw[13], jw[12], jw[11], jw[10], jw[9]});
        chk("hdr_timestamp", timestamp, jw[17]);
        chk("hdr_bits", bits, jw[18]);
        chk("hdr_target", target_bits, jw[19]);
    endtask

    // Supervisor model: completes n cycles after sup_start is first seen.
    task automatic run_complete(input int n, input logic s, input logic [31:0] nn, input logic [255:0] hh);
        repeat (n) @(negedge clk);
        check_header();
        process_complete = 1'b1;
        success   = s;
        nonce_out = nn;
        hash_out  = hh;
        @(negedge clk);
        process_complete = 1'b0;
        success   = ~s;
        nonce_out = $urandom;
        hash_out  = rand256();
        chk("report_latency", bus.res_valid, 1'b1);
        chk("report_sup_reset", sup_reset, 1'b1);
        chk("report_sup_start", sup_start, 1'b0);
    endtask

    task automatic collect(input logic s, input logic to, input logic ab, input logic chk_data,
                           input logic [31:0] nn, input logic [255:0] hh);
        chk("res_valid", bus.res_valid, 1'b1);
        chk("res_success", bus.res_success, s);
        chk("res_timeout", bus.res_timeout, to);
        chk("res_aborted", bus.res_aborted, ab);
        if (chk_data) begin
            chk("res_nonce", bus.res_nonce, nn);
            chk("res_hash", bus.res_hash, hh);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        exp_jobs = (exp_jobs + 1) % 65536;
        chk("res_valid_drop", bus.res_valid, 1'b0);
        chk("jobs_done", jobs_done, exp_jobs);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic good_job(input int n, input logic s, input logic [31:0] nn, input logic [255:0] hh);
        send(20, 19);
        chk("load_error_clear", load_error, 1'b0);
        wait_start();
        run_complete(n, s, nn, hh);
        collect(s, 1'b0, 1'b0, 1'b1, nn, hh);
    endtask

    initial begin
        logic [255:0] h;
        logic [31:0]  nn;
        logic         s;
        int           k;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_sup_reset", sup_reset, 1'b1);
        chk("rst_sup_start", sup_start, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_jobs_done", jobs_done, 16'd0);
        chk("rst_load_error", load_error, 1'b0);
        chk("rst_version", version, 32'd0);
        chk("rst_res_hash", bus.res_hash, 256'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Good job with word-ordering markers; supervisor succeeds after 50 cycles.
        fill_job();
        jw[1] = 32'hAAAA_0001;
        jw[8] = 32'hBBBB_0008;
        h = rand256();
        send(20, 19);
        wait_start();
        chk("prev_low_word", hashPrevBlock[31:0], 32'hAAAA_0001);
        chk("prev_high_word", hashPrevBlock[255:224], 32'hBBBB_0008);
        run_complete(50, 1'b1, 32'h0000_1234, h);
        collect(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, h);

        // Randomized jobs.
        for (int j = 0; j < 4; j++) begin
            fill_job();
            s  = 1'($urandom_range(0, 1));
            nn = $urandom;
            h  = rand256();
            good_job($urandom_range(1, 60), s, nn, h);
        end

        // Short job: in_last on word 5.
        fill_job();
        send(6, 5);
        chk("short_load_error", load_error, 1'b1);
        chk("short_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("short_no_start", sup_start, 1'b0);
            @(negedge clk);
        end
        fill_job();
        good_job(7, 1'b0, $urandom, rand256());

        // Word 19 without in_last: drained until in_last.
        fill_job();
        send(23, 22);
        chk("drain_load_error", load_error, 1'b1);
        chk("drain_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_no_start", sup_start, 1'b0);
            @(negedge clk);
        end

        // Timeout: supervisor never completes.
        fill_job();
        send(20, 19);
        chk("timeout_load_error", load_error, 1'b0);
        wait_start();
        k = 0;
        while (!bus.res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, TO);
        chk("timeout_sup_reset", sup_reset, 1'b1);
        collect(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 256'd0);

        // Abort 10 cycles into RUN, result held 5 cycles with res_ready low.
        fill_job();
        send(20, 19);
        wait_start();
        nonce_out = 32'hDEAD_BEEF;
        hash_out  = rand256();
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_report", bus.res_valid, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("abort_hold_valid", bus.res_valid, 1'b1);
            chk("abort_hold_flag", bus.res_aborted, 1'b1);
            chk("abort_hold_nonce", bus.res_nonce, 32'd0);
            @(negedge clk);
        end
        collect(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 256'd0);

        // jobs_done wrap from a preset of 0xFFFF.
        force dut.jobs_done = 16'hFFFF;
        @(negedge clk);
        release dut.jobs_done;
        exp_jobs = 65535;
        @(negedge clk);
        chk("preset_jobs_done", jobs_done, 16'hFFFF);
        fill_job();
        good_job(3, 1'b1, $urandom, rand256());

        // Asynchronous reset in the middle of RUN.
        fill_job();
        send(20, 19);
        wait_start();
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_jobs = 0;
        chk("arst_sup_reset", sup_reset, 1'b1);
        chk("arst_sup_start", sup_start, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b0);
        chk("arst_jobs_done", jobs_done, exp_jobs);
        chk("arst_prev", hashPrevBlock, 256'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fill_job();
        good_job(4, 1'b1, $urandom, rand256());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
